// File: rtl/shift_pkg.sv
// Shared encodings and defaults for the iterative right shifter.
// Mode encodings match the ALU ctrl_mode field; MODE_RSVD decodes as SRL.
package shift_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    typedef logic [DEF_WIDTH-1:0] word_t;

    localparam logic [1:0] MODE_SRL  = 2'b00;
    localparam logic [1:0] MODE_SRA  = 2'b01;
    localparam logic [1:0] MODE_ROR  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shift_right_stage.sv
// One right-shift stage: shifts by 2^stage_i when en_i, else passes through.
// Combinational, no handshake; vacated bits take fill_bit_i, or the bits shifted out when rotate_i.
module shift_right_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] stage_i,
    input  logic               en_i,
    input  logic               fill_bit_i,
    input  logic               rotate_i,
    output logic [WIDTH-1:0]   data_o
);

    logic [SHAMT_W:0]     amt;
    logic [WIDTH-1:0]     fill_word;
    logic [2*WIDTH-1:0]   cat;

    always_comb begin
        amt       = en_i ? ((SHAMT_W+1)'(1) << stage_i) : '0;
        // For rotate the upper half is the word itself, so shifted-out bits wrap to the top.
        fill_word = rotate_i ? data_i : {WIDTH{fill_bit_i}};
        cat       = {fill_word, data_i};
        data_o    = WIDTH'(cat >> amt);
    end

endmodule

// File: rtl/shift_right_iter.sv
// Iterative right shifter (SRL/SRA, ROR when SHIFTR_ROTATE_EN is defined), one stage per clock.
// Latency SHAMT_W cycles from accepting edge; ctrl_start ignored while busy, accepted in the RDY cycle.
module shift_right_iter
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic [1:0]         ctrl_mode,
    input  logic [WIDTH-1:0]   data_operand,
    input  logic [SHAMT_W-1:0] ctrl_shamt,
    output logic               busy,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY
);

    localparam logic [SHAMT_W-1:0] LAST_STAGE = SHAMT_W'(SHAMT_W - 1);

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] stage_q, stage_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [1:0]         mode_q, mode_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               rdy_q, rdy_d;

    logic               stage_en;
    logic               fill_bit;
    logic               rot_sel;
    logic [WIDTH-1:0]   stage_out;

`ifdef SHIFTR_ROTATE_EN
    assign rot_sel = (mode_q == MODE_ROR);
`else
    assign rot_sel = 1'b0;
`endif

    assign stage_en = |(shamt_q & (SHAMT_W'(1) << stage_q));
    assign fill_bit = (mode_q == MODE_SRA) & sign_q;

    shift_right_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .data_i     (work_q),
        .stage_i    (stage_q),
        .en_i       (stage_en),
        .fill_bit_i (fill_bit),
        .rotate_i   (rot_sel),
        .data_o     (stage_out)
    );

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        work_d   = work_q;
        shamt_d  = shamt_q;
        mode_d   = mode_q;
        sign_d   = sign_q;
        result_d = result_q;
        rdy_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_start) begin
                    work_d  = data_operand;
                    shamt_d = ctrl_shamt;
                    mode_d  = ctrl_mode;
                    sign_d  = data_operand[WIDTH-1];
                    stage_d = LAST_STAGE;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d = stage_out;
                if (stage_q == '0) begin
                    result_d = stage_out;
                    rdy_d    = 1'b1;
                    stage_d  = LAST_STAGE;
                    state_d  = ST_IDLE;
                end else begin
                    stage_d = stage_q - SHAMT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            stage_q  <= LAST_STAGE;
            work_q   <= '0;
            shamt_q  <= '0;
            mode_q   <= MODE_SRL;
            sign_q   <= 1'b0;
            result_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            work_q   <= work_d;
            shamt_q  <= shamt_d;
            mode_q   <= mode_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            rdy_q    <= rdy_d;
        end
    end

    assign busy           = (state_q == ST_SHIFT);
    assign data_result    = result_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_shift_right_iter.sv
// Directed bench for shift_right_iter with hand-computed results.
module tb_shift_right_iter;
    import shift_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_start;
    logic [1:0]  ctrl_mode;
    logic [31:0] data_operand;
    logic [4:0]  ctrl_shamt;
    logic        busy;
    logic [31:0] data_result;
    logic        data_resultRDY;

    int errors = 0;
    int checks = 0;

    shift_right_iter dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_mode      (ctrl_mode),
        .data_operand   (data_operand),
        .ctrl_shamt     (ctrl_shamt),
        .busy           (busy),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a start for one cycle; returns 1 time unit after the accepting edge.
    task automatic start_op(input logic [1:0] mode, input logic [31:0] op, input logic [4:0] sh);
        ctrl_start   = 1'b1;
        ctrl_mode    = mode;
        data_operand = op;
        ctrl_shamt   = sh;
        @(posedge clock); #1;
        ctrl_start   = 1'b0;
        data_operand = 32'hDEAD_BEEF;
        ctrl_shamt   = 5'd3;
        ctrl_mode    = MODE_SRA;
    endtask

    // Wait for RDY; 'elapsed' cycles since the accepting edge have already passed.
    task automatic wait_rdy(input string tag, input int elapsed, input logic [31:0] exp);
        int  cyc;
        bit  seen;
        bit  busy_ok;
        cyc     = elapsed;
        seen    = 1'b0;
        busy_ok = (busy === 1'b1);
        while (!seen && cyc < 12) begin
            @(posedge clock); #1;
            cyc++;
            if (data_resultRDY === 1'b1) seen = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'd5);
        chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_res"}, data_result, exp);
    endtask

    initial begin
        int rdy_cnt;
        reset        = 1'b1;
        ctrl_start   = 1'b0;
        ctrl_mode    = MODE_SRL;
        data_operand = '0;
        ctrl_shamt   = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(data_resultRDY), 32'd0);
        chk("rst_res", data_result, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        start_op(MODE_SRL, 32'h8000_0000, 5'd31);
        wait_rdy("srl31", 0, 32'h0000_0001);
        @(posedge clock); #1;
        chk("rdy_drop", 32'(data_resultRDY), 32'd0);
        chk("res_hold", data_result, 32'h0000_0001);

        start_op(MODE_SRA, 32'h8000_0000, 5'd4);
        wait_rdy("sra4_neg", 0, 32'hF800_0000);
        start_op(MODE_SRA, 32'h7FFF_FFF0, 5'd4);
        wait_rdy("sra4_pos", 0, 32'h07FF_FFFF);
        start_op(MODE_SRA, 32'h8000_0000, 5'd31);
        wait_rdy("sra31", 0, 32'hFFFF_FFFF);
        start_op(MODE_RSVD, 32'h8000_0001, 5'd1);
        wait_rdy("mode11", 0, 32'h4000_0000);

        // shamt 0, then back-to-back start in the RDY cycle.
        start_op(MODE_SRL, 32'h1234_5678, 5'd0);
        wait_rdy("sh0", 0, 32'h1234_5678);
        start_op(MODE_SRA, 32'hFF00_FF00, 5'd8);
        wait_rdy("b2b", 0, 32'hFFFF_00FF);
        @(posedge clock); #1;

        // Starts while busy must be ignored.
        start_op(MODE_SRL, 32'h0000_F000, 5'd12);
        for (int i = 0; i < 3; i++) begin
            ctrl_start   = 1'b1;
            ctrl_mode    = MODE_SRA;
            data_operand = 32'h8765_4321 + 32'(i);
            ctrl_shamt   = 5'd1;
            @(posedge clock); #1;
        end
        ctrl_start = 1'b0;
        wait_rdy("ign", 3, 32'h0000_000F);
        rdy_cnt = 0;
        repeat (8) begin
            @(posedge clock); #1;
            if (data_resultRDY === 1'b1) rdy_cnt++;
        end
        chk("ign_single", 32'(rdy_cnt), 32'd0);
        chk("ign_hold", data_result, 32'h0000_000F);

        // Reset mid-operation.
        start_op(MODE_SRL, 32'hFFFF_FFFF, 5'd4);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res", data_result, 32'h0);
        rdy_cnt = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (data_resultRDY === 1'b1) rdy_cnt++;
        end
        chk("abort_nordy", 32'(rdy_cnt), 32'd0);

        start_op(MODE_ROR, 32'h0000_00FF, 5'd8);
`ifdef SHIFTR_ROTATE_EN
        wait_rdy("ror8", 0, 32'hFF00_0000);
`else
        wait_rdy("ror8", 0, 32'h0000_0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
